rf_dump_reader: RTL and testbench
=================================

// Module: rf_dump_reader
// PURPOSE
//  Halt-time reader for the register file: on a rising edge of hlt it walks
//  regs 0..NREGS-1 through one regfile read port and streams each value,
//  then a snapshot of the cycle counter, on a valid/ready output.
//  Sits beside the regfile on the debug/testbench side. It replaces $display
//  dumping with a synthesizable, back-pressurable stream.
// PARAMETERS
//  NREGS   16  number of registers to dump (power of 2, >=2)
//  AW      4   register address width, log2(NREGS)
//  DW      16  data width of registers and cycle counter
//  RD_LAT  1   cycles from rd_addr change to valid rd_data (>=1)
// PORTS
//  clk        in   1     clock; all state changes on posedge
//  rst        in   1     synchronous reset, active-high
//  hlt        in   1     halt level from core; rising edge starts a dump
//  counter    in   DW    running cycle count, sampled at dump start
//  rd_addr    out  AW    regfile read address (drives Rs)
//  rd_data    in   DW    regfile read data (outRs)
//  out_valid  out  1     stream word valid
//  out_ready  in   1     consumer accepts word when out_valid&out_ready
//  out_data   out  DW    register value, or counter snapshot on last word
//  out_idx    out  AW+1  0..NREGS-1 register index; NREGS = count word
//  out_last   out  1     high with the counter word only
//  busy       out  1     dump in progress (state not IDLE/DONE)
//  done       out  1     dump complete; held until hlt falls
// BEHAVIOUR
//  Reset: state IDLE; rd_addr, out_data, out_idx, idx, wait cnt, snapshot=0;
//   out_valid, out_last, busy, done=0. Reset wins over every other event,
//   including mid-dump: out_valid is 0 after the reset edge, no word resumes.
//  hlt edge: hlt_q registered each cycle; start = hlt & ~hlt_q. hlt_q resets 0.
//  States:
//   IDLE : rd_addr=0. start -> snap<=counter, idx<=0, go ADDR.
//   ADDR : rd_addr<=idx, wcnt<=RD_LAT-1, go WAIT.
//   WAIT : if wcnt==0: out_data<=rd_data, out_idx<=idx, out_valid<=1 -> SEND;
//          else wcnt--. rd_addr held = idx.
//   SEND : out_valid/out_data/out_idx stable until handshake. On handshake:
//          out_valid<=0; idx==NREGS-1 -> COUNT else idx<=idx+1 -> ADDR.
//   COUNT: entered with out_valid<=1, out_data<=snap, out_idx<=NREGS,
//          out_last<=1; hold until handshake, then clear valid/last -> DONE.
//   DONE : done=1. hlt==0 -> IDLE (done clears next cycle).
//  Throughput: with out_ready high each register costs RD_LAT+2 cycles;
//   counter word 1 more. Full dump = NREGS*(RD_LAT+2)+1 cycles after start.
//  start while busy or in DONE: ignored (no restart, no snapshot update).
//  hlt falling mid-dump: dump continues to completion; DONE then exits at once.
//  out_ready high with out_valid low: no effect. out_valid never drops
//   without a handshake or reset (AXI-style stability).
//  Register 0 streamed as read (regfile returns 0); no special-casing.
//  idx is AW bits; never wraps past NREGS-1 (COUNT taken instead).
//  counter snapshot is the value present on the start cycle; later counter
//   changes do not affect out_data on the count word.
// TESTING
//  1 Preload regs[i]=16'h1100+i, counter=16'd250, pulse hlt, out_ready=1 ->
//    17 words: idx 0..15 data 0000,1101..110F (reg0=0), then idx 16 data 00FA
//    with out_last=1; done rises 49 cycles after start (RD_LAT=1).
//  2 out_ready low 5 cycles on idx 3 -> out_valid/out_data=1103 held stable,
//    no skipped or duplicated index after ready returns.
//  3 Assert rst during idx 7 SEND -> out_valid=0, busy=0 after the edge; new
//    hlt edge restarts from idx 0 with fresh counter snapshot.
//  4 Second hlt edge (toggle hlt 0->1) during dump -> ignored, sequence
//    unchanged; in DONE with hlt held high -> done stays 1, no new dump.
//  5 counter increments every cycle during dump -> count word equals value
//    on the start cycle only.
//  6 RD_LAT=3 build, regfile model with 3-cycle read -> same data as test 1,
//    dump length 16*5+1=81 cycles.

Source files
------------

// File: rtl/rf_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_dump_reader_if
// Brief    : Valid/ready word stream carrying register-file dump words.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_dump_reader_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   out_idx;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/rf_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : rf_dump_reader
// Brief    : On a rising hlt edge, reads every register through one regfile
//            read port and streams the values, then a cycle-counter snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module rf_dump_reader #(
    parameter int NREGS  = 16,
    parameter int AW     = 4,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              hlt,
    input  wire  [DW-1:0]    counter,
    output logic [AW-1:0]    rd_addr,
    input  wire  [DW-1:0]    rd_data,
    rf_dump_reader_if.master out_s,
    output logic             busy,
    output logic             done
);
    // Wait counter only needs to hold RD_LAT-1.
    localparam int                c_WCW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_WCW-1:0]  c_WAIT_INIT = c_WCW'(RD_LAT - 1);
    localparam logic [c_WCW-1:0]  c_WCNT_ONE  = c_WCW'(1);
    localparam logic [AW-1:0]     c_LAST_IDX  = AW'(NREGS - 1);
    localparam logic [AW-1:0]     c_IDX_ONE   = AW'(1);
    localparam logic [AW:0]       c_CNT_IDX   = (AW+1)'(NREGS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_COUNT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state,     w_state;
    logic               r_hlt_q;
    logic [AW-1:0]      r_idx,       w_idx;
    logic [c_WCW-1:0]   r_wcnt,      w_wcnt;
    logic [DW-1:0]      r_snap,      w_snap;
    logic [AW-1:0]      r_rd_addr,   w_rd_addr;
    logic [DW-1:0]      r_out_data,  w_out_data;
    logic [AW:0]        r_out_idx,   w_out_idx;
    logic               r_out_valid, w_out_valid;
    logic               r_out_last,  w_out_last;
    logic               w_start;
    logic               w_hs;

    assign w_start = hlt & ~r_hlt_q;
    assign w_hs    = r_out_valid & out_s.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hlt_q     <= 1'b0;
            r_idx       <= '0;
            r_wcnt      <= '0;
            r_snap      <= '0;
            r_rd_addr   <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_hlt_q     <= hlt;
            r_idx       <= w_idx;
            r_wcnt      <= w_wcnt;
            r_snap      <= w_snap;
            r_rd_addr   <= w_rd_addr;
            r_out_data  <= w_out_data;
            r_out_idx   <= w_out_idx;
            r_out_valid <= w_out_valid;
            r_out_last  <= w_out_last;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_wcnt      = r_wcnt;
        w_snap      = r_snap;
        w_rd_addr   = r_rd_addr;
        w_out_data  = r_out_data;
        w_out_idx   = r_out_idx;
        w_out_valid = r_out_valid;
        w_out_last  = r_out_last;

        case (r_state)
            S_IDLE: begin
                w_rd_addr = '0;
                if (w_start) begin
                    w_snap  = counter;
                    w_idx   = '0;
                    w_state = S_ADDR;
                end
            end
            S_ADDR: begin
                w_rd_addr = r_idx;
                w_wcnt    = c_WAIT_INIT;
                w_state   = S_WAIT;
            end
            S_WAIT: begin
                if (r_wcnt == '0) begin
                    w_out_data  = rd_data;
                    w_out_idx   = {1'b0, r_idx};
                    w_out_valid = 1'b1;
                    w_state     = S_SEND;
                end else begin
                    w_wcnt = r_wcnt - c_WCNT_ONE;
                end
            end
            S_SEND: begin
                if (w_hs) begin
                    w_out_valid = 1'b0;
                    if (r_idx == c_LAST_IDX) begin
                        // Counter word follows the last register back-to-back.
                        w_out_valid = 1'b1;
                        w_out_data  = r_snap;
                        w_out_idx   = c_CNT_IDX;
                        w_out_last  = 1'b1;
                        w_state     = S_COUNT;
                    end else begin
                        w_idx   = r_idx + c_IDX_ONE;
                        w_state = S_ADDR;
                    end
                end
            end
            S_COUNT: begin
                if (w_hs) begin
                    w_out_valid = 1'b0;
                    w_out_last  = 1'b0;
                    w_state     = S_DONE;
                end
            end
            S_DONE: begin
                if (!hlt) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign rd_addr         = r_rd_addr;
    assign out_s.out_valid = r_out_valid;
    assign out_s.out_data  = r_out_data;
    assign out_s.out_idx   = r_out_idx;
    assign out_s.out_last  = r_out_last;
    assign busy            = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done            = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_rf_dump_reader.sv
`default_nettype none
// Bench for rf_dump_reader: two instances (read latency 1 and 3) driven with
// randomized register contents, counter values and back-pressure.
module tb_rf_dump_reader;
    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int DW    = 16;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          hlt1 = 1'b0;
    logic          hlt2 = 1'b0;
    logic [DW-1:0] counter = '0;
    logic [AW-1:0] rd_addr1, rd_addr2, a_p1, a_p2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          busy1, done1, busy2, done2;
    logic [DW-1:0] mem [NREGS];

    int checks = 0;
    int errors = 0;
    int done_t;

    logic [DW-1:0] q_d[$];
    logic [AW:0]   q_i[$];
    logic          q_l[$];
    logic [DW-1:0] exp_d[$];
    logic [AW:0]   exp_i[$];
    logic          exp_l[$];

    rf_dump_reader_if #(.AW(AW), .DW(DW)) if1 ();
    rf_dump_reader_if #(.AW(AW), .DW(DW)) if2 ();

    always #5 clk = ~clk;

    // Regfile models: register 0 always reads as zero.
    assign rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
    always_ff @(posedge clk) begin
        a_p1 <= rd_addr2;
        a_p2 <= a_p1;
    end
    assign rd_data2 = (a_p2 == '0) ? '0 : mem[a_p2];

    rf_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .hlt(hlt1), .counter(counter),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .out_s(if1),
        .busy(busy1), .done(done1)
    );

    rf_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW), .RD_LAT(3)) dut2 (
        .clk(clk), .rst(rst), .hlt(hlt2), .counter(counter),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .out_s(if2),
        .busy(busy2), .done(done2)
    );

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < NREGS; i++)
            mem[i] = rnd ? 16'($urandom) : 16'h1100 + 16'(i);
    endtask

    // Expected stream: every register as read, then the counter snapshot.
    task automatic build_expected(input logic [DW-1:0] snap);
        exp_d.delete(); exp_i.delete(); exp_l.delete();
        for (int i = 0; i < NREGS; i++) begin
            exp_d.push_back((i == 0) ? '0 : mem[i]);
            exp_i.push_back((AW+1)'(i));
            exp_l.push_back(1'b0);
        end
        exp_d.push_back(snap);
        exp_i.push_back((AW+1)'(NREGS));
        exp_l.push_back(1'b1);
    endtask

    task automatic idle_gap();
        hlt1 = 1'b0;
        hlt2 = 1'b0;
        if1.out_ready = 1'b0;
        if2.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Drives ready and records accepted words; t counts edges from the start edge.
    task automatic collect(input bit sel, input bit rnd_ready, input bit inc_cnt,
                           input int tog_at, input bit tog_back, input int max_t,
                           output bit timeout);
        bit            fin;
        logic          rdy, v, l, dn;
        logic [DW-1:0] d;
        logic [AW:0]   ix;
        fin = 1'b0;
        done_t = -1;
        q_d.delete(); q_i.delete(); q_l.delete();
        for (int t = 0; t < max_t && !fin; t++) begin
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel) begin
                if2.out_ready = rdy;
                v = if2.out_valid; d = if2.out_data; ix = if2.out_idx; l = if2.out_last;
                if (t == tog_at) hlt2 = 1'b0;
                if (tog_back && t == tog_at + 1) hlt2 = 1'b1;
            end else begin
                if1.out_ready = rdy;
                v = if1.out_valid; d = if1.out_data; ix = if1.out_idx; l = if1.out_last;
                if (t == tog_at) hlt1 = 1'b0;
                if (tog_back && t == tog_at + 1) hlt1 = 1'b1;
            end
            if (v && rdy) begin
                q_d.push_back(d); q_i.push_back(ix); q_l.push_back(l);
                if (l) fin = 1'b1;
            end
            @(posedge clk); #1;
            if (inc_cnt) counter = counter + 16'd1;
            dn = sel ? done2 : done1;
            if (dn && done_t < 0) done_t = t;
        end
        timeout = !fin;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if1.out_valid); end
        checks++; if (if1.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", if1.out_last); end
        checks++; if (if1.out_data !== 16'h0 || if1.out_idx !== 5'd0) begin errors++; $display("FAIL reset_word: got data=%h idx=%0d expected 0/0", if1.out_data, if1.out_idx); end
        checks++; if (rd_addr1 !== 4'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr1); end
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got busy=%b done=%b expected 0/0", busy1, done1); end
        checks++; if (if2.out_valid !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: got valid=%b busy=%b done=%b expected 0/0/0", if2.out_valid, busy2, done2); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit to;
        fill_mem(1'b0);
        counter = 16'd250;
        build_expected(16'd250);
        hlt1 = 1'b1;
        collect(1'b0, 1'b0, 1'b0, -1, 1'b0, 200, to);
        checks++; if (to || q_d.size() != exp_d.size()) begin errors++; $display("FAIL basic_count: got %0d words expected %0d", q_d.size(), exp_d.size()); end
        for (int i = 0; i < q_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q_d[i] !== exp_d[i] || q_i[i] !== exp_i[i] || q_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL basic_word %0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b", i, q_d[i], q_i[i], q_l[i], exp_d[i], exp_i[i], exp_l[i]);
            end
        end
        checks++; if (done_t != 49) begin errors++; $display("FAIL basic_done_time: got %0d expected 49", done_t); end
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0 || if1.out_valid !== 1'b0) begin errors++; $display("FAIL basic_done_state: got done=%b busy=%b valid=%b expected 1/0/0", done1, busy1, if1.out_valid); end
        hlt1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL basic_done_clear: got %b expected 0", done1); end
    endtask

    task automatic test_backpressure();
        int stall;
        bit fin;
        logic rdy;
        stall = 0;
        fin = 1'b0;
        fill_mem(1'b0);
        counter = 16'h1234;
        build_expected(16'h1234);
        q_d.delete(); q_i.delete(); q_l.delete();
        hlt1 = 1'b1;
        for (int t = 0; t < 300 && !fin; t++) begin
            rdy = 1'b1;
            if (if1.out_valid && if1.out_idx == 5'd3 && stall < 5) begin
                rdy = 1'b0;
                stall++;
                checks++;
                if (if1.out_data !== 16'h1103 || if1.out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d: got data=%h last=%b expected 1103/0", stall, if1.out_data, if1.out_last);
                end
            end
            if1.out_ready = rdy;
            if (if1.out_valid && rdy) begin
                q_d.push_back(if1.out_data); q_i.push_back(if1.out_idx); q_l.push_back(if1.out_last);
                if (if1.out_last) fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++; if (stall != 5) begin errors++; $display("FAIL stall_length: got %0d stalled cycles expected 5", stall); end
        checks++; if (!fin || q_d.size() != exp_d.size()) begin errors++; $display("FAIL stall_count: got %0d words expected %0d", q_d.size(), exp_d.size()); end
        for (int i = 0; i < q_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q_d[i] !== exp_d[i] || q_i[i] !== exp_i[i] || q_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL stall_word %0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b", i, q_d[i], q_i[i], q_l[i], exp_d[i], exp_i[i], exp_l[i]);
            end
        end
    endtask

    // Random ready and a free-running counter: snapshot must be the start-cycle value.
    task automatic test_random();
        bit to;
        logic [DW-1:0] snap;
        for (int n = 0; n < 3; n++) begin
            fill_mem(1'b1);
            counter = 16'($urandom);
            snap = counter;
            build_expected(snap);
            hlt1 = 1'b1;
            collect(1'b0, 1'b1, 1'b1, -1, 1'b0, 3000, to);
            checks++; if (to || q_d.size() != exp_d.size()) begin errors++; $display("FAIL random_count run %0d: got %0d words expected %0d", n, q_d.size(), exp_d.size()); end
            for (int i = 0; i < q_d.size() && i < exp_d.size(); i++) begin
                checks++;
                if (q_d[i] !== exp_d[i] || q_i[i] !== exp_i[i] || q_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL random_word run %0d word %0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b", n, i, q_d[i], q_i[i], q_l[i], exp_d[i], exp_i[i], exp_l[i]);
                end
            end
            idle_gap();
        end
    endtask

    task automatic test_reset_mid();
        bit found, to;
        logic [DW-1:0] snap;
        found = 1'b0;
        fill_mem(1'b1);
        counter = 16'($urandom);
        if1.out_ready = 1'b1;
        hlt1 = 1'b1;
        for (int t = 0; t < 200 && !found; t++) begin
            if (if1.out_valid && if1.out_idx == 5'd7) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_reach: got no idx 7 word expected one"); end
        rst = 1'b1;
        hlt1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (if1.out_valid !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || if1.out_last !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got valid=%b busy=%b done=%b last=%b expected 0/0/0/0", if1.out_valid, busy1, done1, if1.out_last); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (if1.out_valid !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume: got valid=%b busy=%b expected 0/0", if1.out_valid, busy1); end
        counter = 16'($urandom);
        snap = counter;
        build_expected(snap);
        hlt1 = 1'b1;
        collect(1'b0, 1'b0, 1'b1, -1, 1'b0, 200, to);
        checks++; if (to || q_d.size() != exp_d.size()) begin errors++; $display("FAIL rstmid_count: got %0d words expected %0d", q_d.size(), exp_d.size()); end
        for (int i = 0; i < q_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q_d[i] !== exp_d[i] || q_i[i] !== exp_i[i] || q_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL rstmid_word %0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b", i, q_d[i], q_i[i], q_l[i], exp_d[i], exp_i[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_retrigger();
        bit to;
        fill_mem(1'b1);
        counter = 16'($urandom);
        build_expected(counter);
        hlt1 = 1'b1;
        collect(1'b0, 1'b0, 1'b1, 10, 1'b1, 200, to);
        checks++; if (to || q_d.size() != exp_d.size()) begin errors++; $display("FAIL retrig_count: got %0d words expected %0d", q_d.size(), exp_d.size()); end
        for (int i = 0; i < q_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q_d[i] !== exp_d[i] || q_i[i] !== exp_i[i] || q_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL retrig_word %0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b", i, q_d[i], q_i[i], q_l[i], exp_d[i], exp_i[i], exp_l[i]);
            end
        end
        checks++; if (done_t != 49) begin errors++; $display("FAIL retrig_done_time: got %0d expected 49", done_t); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || if1.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL retrig_done_hold cycle %0d: got done=%b busy=%b valid=%b expected 1/0/0", c, done1, busy1, if1.out_valid);
            end
        end
        hlt1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL retrig_done_clear: got %b expected 0", done1); end
    endtask

    task automatic test_hlt_fall();
        bit to;
        fill_mem(1'b1);
        counter = 16'($urandom);
        build_expected(counter);
        hlt1 = 1'b1;
        collect(1'b0, 1'b0, 1'b0, 5, 1'b0, 200, to);
        checks++; if (to || q_d.size() != exp_d.size()) begin errors++; $display("FAIL hltfall_count: got %0d words expected %0d", q_d.size(), exp_d.size()); end
        for (int i = 0; i < q_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q_d[i] !== exp_d[i] || q_i[i] !== exp_i[i] || q_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL hltfall_word %0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b", i, q_d[i], q_i[i], q_l[i], exp_d[i], exp_i[i], exp_l[i]);
            end
        end
        checks++; if (done_t != 49) begin errors++; $display("FAIL hltfall_done_time: got %0d expected 49", done_t); end
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL hltfall_exit: got done=%b busy=%b expected 0/0", done1, busy1); end
    endtask

    task automatic test_rd_lat3();
        bit to;
        fill_mem(1'b0);
        counter = 16'($urandom);
        build_expected(counter);
        hlt2 = 1'b1;
        collect(1'b1, 1'b0, 1'b0, -1, 1'b0, 300, to);
        checks++; if (to || q_d.size() != exp_d.size()) begin errors++; $display("FAIL lat3_count: got %0d words expected %0d", q_d.size(), exp_d.size()); end
        for (int i = 0; i < q_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (q_d[i] !== exp_d[i] || q_i[i] !== exp_i[i] || q_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL lat3_word %0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b", i, q_d[i], q_i[i], q_l[i], exp_d[i], exp_i[i], exp_l[i]);
            end
        end
        checks++; if (done_t != 81) begin errors++; $display("FAIL lat3_done_time: got %0d expected 81", done_t); end
        hlt2 = 1'b0;
    endtask

    initial begin
        if1.out_ready = 1'b0;
        if2.out_ready = 1'b0;
        test_reset();
        test_basic();
        idle_gap();
        test_backpressure();
        idle_gap();
        test_random();
        test_reset_mid();
        idle_gap();
        test_retrigger();
        idle_gap();
        test_hlt_fall();
        idle_gap();
        test_rd_lat3();
        idle_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
